vga_scaled_display: RTL and testbench

Parametrised VGA display engine that combines the pixel-clock divider, sync timing generator, scaled frame-buffer address generator and per-frame layer mux in one block. It reads a 1-bit mono layer (menu) and a 12-bit colour layer (game) from external block RAMs, composites them according to a mode that switches only at frame boundaries, and drives the VGA pins. It runs entirely on the system clock using a pixel-tick enable, so no derived pixel clock is needed.

---
 rtl/vga_scaled_display.sv | 141 ++++++++++++++
 tb/tb_vga_scaled_display.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled_display.sv
// VGA engine: pixel-tick divider, sync timing, scaled frame-buffer addressing and a
// per-frame mono/colour layer mux, all running on the system clock with a tick enable.
module vga_scaled_display #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned ADDR_W      = 17,
    parameter logic [11:0] FG_COLOR    = 12'h000,
    parameter logic [11:0] BG_COLOR    = 12'hfff
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_req,
    input  logic              mono_data,
    input  logic [11:0]       color_data,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [3:0]        vgaRed,
    output logic [3:0]        vgaGreen,
    output logic [3:0]        vgaBlue,
    output logic              hsync,
    output logic              vsync,
    output logic              pixel_tick,
    output logic              frame_start,
    output logic [1:0]        mode_active,
    output logic [9:0]        h_cnt,
    output logic [9:0]        v_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned H_BUF   = H_ACTIVE >> SCALE_SHIFT;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [9:0]        h_q, h_d, v_q, v_d;
    logic [1:0]        mode_q, mode_d;
    logic              act1_q, act1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic              hsync_q, vsync_q;
    logic [11:0]       rgb_q, rgb_d, pix;
    logic [31:0]       addr_full;
    logic              tick, wrap;

    assign tick = (div_q == DIV_LAST);
    assign wrap = tick && (h_q == H_LAST) && (v_q == V_LAST);

    // Stage 0: divider and raw counters; the mode only changes at the frame wrap
    always_comb begin
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        h_d    = h_q + 10'd1;
        v_d    = v_q;
        mode_d = mode_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
        if (wrap) begin
            mode_d = mode_req;
        end
    end

    // Stage 1: visibility, scaled buffer address and raw sync levels
    always_comb begin
        addr_full = (32'(h_q) >> SCALE_SHIFT) + H_BUF * (32'(v_q) >> SCALE_SHIFT);
        act1_d    = (h_q < H_ACT) && (v_q < V_ACT);
        addr1_d   = act1_d ? addr_full[ADDR_W-1:0] : '0;
        hs1_d     = !((h_q >= H_SS) && (h_q < H_SE));
        vs1_d     = !((v_q >= V_SS) && (v_q < V_SE));
    end

    // Stage 2: RAM data has settled for a full tick by the time it is sampled here
    always_comb begin
        unique case (mode_q)
            2'd0:    pix = mono_data ? FG_COLOR : BG_COLOR;
            2'd1:    pix = color_data;
            2'd2:    pix = mono_data ? FG_COLOR : color_data;
            default: pix = 12'h000;
        endcase
        rgb_d = act1_q ? pix : 12'h000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            mode_q  <= '0;
            act1_q  <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            addr1_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            div_q <= div_d;
            if (tick) begin
                h_q     <= h_d;
                v_q     <= v_d;
                mode_q  <= mode_d;
                act1_q  <= act1_d;
                hs1_q   <= hs1_d;
                vs1_q   <= vs1_d;
                addr1_q <= addr1_d;
                hsync_q <= hs1_q;
                vsync_q <= vs1_q;
                rgb_q   <= rgb_d;
            end
        end
    end

    assign frame_addr  = addr1_q;
    assign vgaRed      = rgb_q[11:8];
    assign vgaGreen    = rgb_q[7:4];
    assign vgaBlue     = rgb_q[3:0];
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_tick  = tick;
    assign frame_start = wrap;
    assign mode_active = mode_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;

endmodule

// File: tb/tb_vga_scaled_display.sv
// Self-checking bench for vga_scaled_display on a shrunken raster; expected values come
// from closed-form position arithmetic driven by the number of ticks since reset.
module tb_vga_scaled_display;

    localparam int HA = 20, HFP = 2, HSW = 4, HBP = 2;
    localparam int VA = 10, VFP = 1, VSW = 2, VBP = 2;
    localparam int CD = 4, SS = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [11:0] FG = 12'h000, BG = 12'hfff;

    logic        clk = 1'b0, rst = 1'b0;
    logic [1:0]  mode_req = 2'd0;
    logic        mono_data;
    logic [11:0] color_data;
    logic [16:0] frame_addr;
    logic [3:0]  vgaRed, vgaGreen, vgaBlue;
    logic        hsync, vsync, pixel_tick, frame_start;
    logic [1:0]  mode_active;
    logic [9:0]  h_cnt, v_cnt;

    logic        mono_mem  [0:63];
    logic [11:0] color_mem [0:63];

    int checks = 0, errors = 0;
    int m_clks = 0, m_ticks = 0;
    logic [1:0] m_mode = 2'd0, m_rgb_mode = 2'd0;

    vga_scaled_display #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SCALE_SHIFT(SS), .CLK_DIV(CD), .ADDR_W(17)
    ) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .mono_data(mono_data),
        .color_data(color_data), .frame_addr(frame_addr), .vgaRed(vgaRed),
        .vgaGreen(vgaGreen), .vgaBlue(vgaBlue), .hsync(hsync), .vsync(vsync),
        .pixel_tick(pixel_tick), .frame_start(frame_start), .mode_active(mode_active),
        .h_cnt(h_cnt), .v_cnt(v_cnt)
    );

    always #5 clk = ~clk;

    // Zero-latency RAMs
    assign mono_data  = mono_mem[frame_addr[5:0]];
    assign color_data = color_mem[frame_addr[5:0]];

    // Reference timebase: clocks and ticks since reset, mode latched at each frame end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clks <= 0; m_ticks <= 0; m_mode <= 2'd0; m_rgb_mode <= 2'd0;
        end else begin
            m_clks <= m_clks + 1;
            if (m_clks % CD == CD - 1) begin
                m_ticks    <= m_ticks + 1;
                m_rgb_mode <= m_mode;
                if (m_ticks % FRAME == FRAME - 1) m_mode <= mode_req;
            end
        end
    end

    function automatic int ph(int p); return (p % FRAME) % HT; endfunction
    function automatic int pv(int p); return (p % FRAME) / HT; endfunction
    function automatic bit vis(int p); return ph(p) < HA && pv(p) < VA; endfunction
    function automatic int exp_addr(int p);
        return vis(p) ? (ph(p) >> SS) + (HA >> SS) * (pv(p) >> SS) : 0;
    endfunction
    function automatic logic exp_hs(int p);
        return !(ph(p) >= HA + HFP && ph(p) < HA + HFP + HSW);
    endfunction
    function automatic logic exp_vs(int p);
        return !(pv(p) >= VA + VFP && pv(p) < VA + VFP + VSW);
    endfunction
    function automatic logic [11:0] exp_rgb(int p, logic [1:0] md);
        int a;
        if (!vis(p)) return 12'h000;
        a = exp_addr(p);
        case (md)
            2'd0:    return mono_mem[a] ? FG : BG;
            2'd1:    return color_mem[a];
            2'd2:    return mono_mem[a] ? FG : color_mem[a];
            default: return 12'h000;
        endcase
    endfunction

    task automatic fill(input logic mono, input logic [11:0] col);
        for (int i = 0; i < 64; i++) begin mono_mem[i] = mono; color_mem[i] = col; end
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((m_ticks % FRAME) != target && n < 2 * FRAME * CD);
        if ((m_ticks % FRAME) != target) begin
            errors++;
            $display("FAIL wait_pos: position %0d, required %0d", m_ticks % FRAME, target);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks += 6;
        if (h_cnt !== 10'd0 || v_cnt !== 10'd0) begin
            errors++; $display("FAIL rst_cnt: h=%0d v=%0d, required 0 0", h_cnt, v_cnt);
        end
        if (frame_addr !== 17'd0) begin
            errors++; $display("FAIL rst_addr: got %0d, required 0", frame_addr);
        end
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000) begin
            errors++; $display("FAIL rst_rgb: got %h, required 000", {vgaRed, vgaGreen, vgaBlue});
        end
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++; $display("FAIL rst_sync: got %b%b, required 11", hsync, vsync);
        end
        if (pixel_tick !== 1'b0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL rst_pulse: got %b%b, required 00", pixel_tick, frame_start);
        end
        if (mode_active !== 2'd0) begin
            errors++; $display("FAIL rst_mode: got %0d, required 0", mode_active);
        end
        repeat (3) @(posedge clk);
        mode_req = 2'($urandom_range(0, 3));
        @(negedge clk) rst = 1'b0;
    endtask

    // Every clock compare all outputs with the closed-form reference
    task automatic test_sweep(input int nclk);
        int t;
        logic [11:0] e_rgb;
        for (int i = 0; i < 64; i++) begin
            mono_mem[i] = 1'($urandom); color_mem[i] = 12'($urandom);
        end
        for (int i = 0; i < nclk; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) mode_req = 2'($urandom_range(0, 3));
            t = m_ticks;
            e_rgb = (t >= 2) ? exp_rgb(t - 2, m_rgb_mode) : 12'h000;
            checks += 8;
            if (pixel_tick !== (m_clks % CD == CD - 1)) begin
                errors++; $display("FAIL sweep_tick clk %0d: got %b", m_clks, pixel_tick);
            end
            if (frame_start !== ((m_clks % CD == CD - 1) && (t % FRAME == FRAME - 1))) begin
                errors++; $display("FAIL sweep_fs tick %0d: got %b", t, frame_start);
            end
            if (h_cnt !== 10'(ph(t)) || v_cnt !== 10'(pv(t))) begin
                errors++;
                $display("FAIL sweep_cnt tick %0d: got %0d,%0d required %0d,%0d",
                         t, h_cnt, v_cnt, ph(t), pv(t));
            end
            if (frame_addr !== 17'((t >= 1) ? exp_addr(t - 1) : 0)) begin
                errors++; $display("FAIL sweep_addr tick %0d: got %0d", t, frame_addr);
            end
            if (hsync !== ((t >= 2) ? exp_hs(t - 2) : 1'b1)) begin
                errors++; $display("FAIL sweep_hsync tick %0d: got %b", t, hsync);
            end
            if (vsync !== ((t >= 2) ? exp_vs(t - 2) : 1'b1)) begin
                errors++; $display("FAIL sweep_vsync tick %0d: got %b", t, vsync);
            end
            if ({vgaRed, vgaGreen, vgaBlue} !== e_rgb) begin
                errors++;
                $display("FAIL sweep_rgb tick %0d: got %h required %h",
                         t, {vgaRed, vgaGreen, vgaBlue}, e_rgb);
            end
            if (mode_active !== m_mode) begin
                errors++;
                $display("FAIL sweep_mode tick %0d: got %0d required %0d", t, mode_active, m_mode);
            end
        end
    endtask

    task automatic test_address();
        int pos [5] = '{1, 2, 3, 21, 272};
        int exp [5] = '{0, 0, 1, 0, 49};
        for (int i = 0; i < 5; i++) begin
            wait_pos(pos[i]);
            checks++;
            if (frame_addr !== 17'(exp[i])) begin
                errors++;
                $display("FAIL addr_%0d: got %0d, required %0d", pos[i] - 1, frame_addr, exp[i]);
            end
        end
    endtask

    task automatic test_modes();
        mode_req = 2'd0; fill(1'b1, 12'h000);
        wait_pos(0);
        wait_pos(2 * HT + 3 + 2);
        checks++;
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000) begin
            errors++; $display("FAIL mode0_mono1: got %h, required 000", {vgaRed, vgaGreen, vgaBlue});
        end
        fill(1'b0, 12'h000);
        wait_pos(3 * HT + 5 + 2);
        checks++;
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'hfff) begin
            errors++; $display("FAIL mode0_mono0: got %h, required fff", {vgaRed, vgaGreen, vgaBlue});
        end
        wait_pos(3 * HT + HA + 1 + 2);
        checks++;
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000) begin
            errors++; $display("FAIL mode0_blank: got %h, required 000", {vgaRed, vgaGreen, vgaBlue});
        end
        mode_req = 2'd2; fill(1'b0, 12'h5a3);
        wait_pos(0);
        checks++;
        if (mode_active !== 2'd2) begin
            errors++; $display("FAIL mode2_latch: got %0d, required 2", mode_active);
        end
        wait_pos(4 * HT + 4 + 2);
        checks++;
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'h5a3) begin
            errors++; $display("FAIL mode2_color: got %h, required 5a3", {vgaRed, vgaGreen, vgaBlue});
        end
        fill(1'b1, 12'h5a3);
        wait_pos(6 * HT + 6 + 2);
        checks++;
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000) begin
            errors++; $display("FAIL mode2_mono: got %h, required 000", {vgaRed, vgaGreen, vgaBlue});
        end
        mode_req = 2'd3; fill(1'b0, 12'h5a3);
        wait_pos(0);
        wait_pos(HT + HA + HFP + 2);
        checks++;
        if (hsync !== 1'b0) begin
            errors++; $display("FAIL mode3_hsync_low: got %b, required 0", hsync);
        end
        wait_pos(HT + HA + HFP + HSW + 2);
        checks++;
        if (hsync !== 1'b1) begin
            errors++; $display("FAIL mode3_hsync_high: got %b, required 1", hsync);
        end
        wait_pos(4 * HT + 4 + 2);
        checks++;
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000) begin
            errors++; $display("FAIL mode3_rgb: got %h, required 000", {vgaRed, vgaGreen, vgaBlue});
        end
        wait_pos((VA + VFP) * HT + 2);
        checks++;
        if (vsync !== 1'b0) begin
            errors++; $display("FAIL mode3_vsync: got %b, required 0", vsync);
        end
    endtask

    task automatic test_mode_switch();
        mode_req = 2'd0;
        wait_pos(0);
        wait_pos(5 * HT);
        mode_req = 2'd1;
        wait_pos(8 * HT);
        checks++;
        if (mode_active !== 2'd0) begin
            errors++; $display("FAIL switch_mid: got %0d, required 0", mode_active);
        end
        wait_pos(FRAME - 1);
        repeat (3) @(negedge clk);
        checks += 2;
        if (pixel_tick !== 1'b1 || frame_start !== 1'b1) begin
            errors++; $display("FAIL switch_wrap: tick/fs %b%b, required 11", pixel_tick, frame_start);
        end
        if (mode_active !== 2'd0) begin
            errors++; $display("FAIL switch_before: got %0d, required 0", mode_active);
        end
        @(negedge clk);
        checks += 2;
        if (mode_active !== 2'd1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL switch_after: mode %0d fs %b, required 1 0", mode_active, frame_start);
        end
        if (h_cnt !== 10'd0 || v_cnt !== 10'd0) begin
            errors++; $display("FAIL switch_cnt: got %0d,%0d, required 0,0", h_cnt, v_cnt);
        end
    endtask

    task automatic test_reset_mid();
        wait_pos(3 * HT + 7);
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (h_cnt !== 10'd0 || v_cnt !== 10'd0 || frame_addr !== 17'd0) begin
            errors++;
            $display("FAIL midrst_cnt: h=%0d v=%0d addr=%0d, required 0", h_cnt, v_cnt, frame_addr);
        end
        if (mode_active !== 2'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: mode %0d sync %b%b, required 0 11",
                     mode_active, hsync, vsync);
        end
        if ({vgaRed, vgaGreen, vgaBlue} !== 12'h000 || pixel_tick !== 1'b0) begin
            errors++;
            $display("FAIL midrst_out: rgb %h tick %b, required 000 0",
                     {vgaRed, vgaGreen, vgaBlue}, pixel_tick);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (pixel_tick !== (k == 3) || h_cnt !== ((k == 4) ? 10'd1 : 10'd0)) begin
                errors++;
                $display("FAIL midrst_restart clk %0d: tick %b h %0d, required %b %0d",
                         k, pixel_tick, h_cnt, k == 3, (k == 4) ? 1 : 0);
            end
        end
    endtask

    initial begin
        fill(1'b0, 12'h000);
        test_reset();
        test_sweep(2 * FRAME * CD + 100);
        test_address();
        test_modes();
        test_mode_switch();
        test_reset_mid();
        test_sweep(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
